// File: rtl/slc3_mem_if.sv
// SLC-3 memory-access sequencer: single-word SRAM read/write with a fixed wait count,
// plus the 0xFFFF switch/hex-display I/O location that bypasses the SRAM.
module slc3_mem_if #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          ADDR_W      = 20,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: mem_req is sampled only in IDLE; mem_ready pulses for exactly one
  // cycle when the access completes, and control must drop mem_req in that cycle
  // unless it wants the next transaction to start in the following IDLE cycle.
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [15:0]       mar,
  input  logic [15:0]       mdr_out,
  output logic [15:0]       mdr_in,
  output logic              mem_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  input  logic [15:0]       sw,
  output logic [15:0]       hex_out,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, ACCESS, IO, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [15:0] data_q;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      mdr_in     <= '0;
      hex_out    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      mem_ready  <= 1'b0;
      busy       <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_req) begin
            we_q   <= mem_we;
            data_q <= mdr_out;
            busy   <= 1'b1;
            if (mar == IO_ADDR) begin
              state <= IO;
            end else begin
              // Strobes, address and data are registered here so they are clean
              // and stable from the first ACCESS cycle onward.
              state     <= ACCESS;
              cnt       <= CNT_INIT;
              sram_addr <= {{(ADDR_W-16){1'b0}}, mar};
              if (mem_we) sram_wdata <= mdr_out;
              sram_ce_n <= 1'b0;
              sram_oe_n <= mem_we;
              sram_we_n <= ~mem_we;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_q) mdr_in <= sram_rdata;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            mem_ready <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        IO: begin
          if (we_q) hex_out <= data_q;
          else      mdr_in  <= sw;
          mem_ready <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          mem_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/slc3_mem_if.md
# slc3_mem_if

Memory-access sequencer between the SLC-3 datapath and the external asynchronous SRAM. It takes a single-word read or write request from the control FSM, drives the SRAM strobes for a fixed number of wait cycles, and returns read data on the datapath's MDR load input. It also acknowledges completion with a one-cycle ready pulse. Address 0xFFFF is memory-mapped I/O and never touches the SRAM: reads return the switches, writes load the hex-display register.

## Interface
- WAIT_CYCLES, 2, SRAM access cycles with strobes asserted; legal range 1..15
- ADDR_W, 20, SRAM address width; the 16-bit MAR is zero-extended
- IO_ADDR, 16'hFFFF, address decoded as switch/hex I/O
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- mem_req  in  1  access request from control FSM; sampled only in IDLE
- mem_we  in  1  1 = write, 0 = read; sampled with mem_req
- mar  in  16  access address (datapath MAR)
- mdr_out  in  16  write data (datapath MDR_OUT)
- mdr_in  out  16  read data to datapath MDR_In; held between reads
- mem_ready  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- sram_addr  out  ADDR_W  registered SRAM address
- sram_wdata  out  16  registered SRAM write data
- sram_rdata  in  16  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes, registered
- sw  in  16  switch inputs
- hex_out  out  16  hex-display register

## Operation
- States: IDLE, ACCESS, IO, DONE.
- IDLE: if mem_req=1, latch mar, mem_we and mdr_out.
  - If mar==IO_ADDR, go to IO.
  - Otherwise, go to ACCESS and load the wait counter with WAIT_CYCLES-1.
- ACCESS: sram_ce_n=0 throughout.
  - Read: sram_oe_n=0, sram_we_n=1.
  - Write: sram_we_n=0, sram_oe_n=1, and sram_wdata holds the latched data.
  - The counter decrements each cycle. When it reaches 0, a read captures sram_rdata into mdr_in, and the state goes to DONE.
- IO: no SRAM strobes.
  - Read: mdr_in <= sw.
  - Write: hex_out <= latched data.
  - Next state: DONE.
- DONE: mem_ready=1 and all strobes inactive. Next state is always IDLE.
- Control must drop mem_req in the cycle it sees mem_ready. A mem_req still high in IDLE starts a new transaction.
- mem_req and mem_we changes outside IDLE are ignored. mar and mdr_out changes after the request cycle have no effect.
- A write never alters mdr_in. A read never alters hex_out.
- sram_addr = {(ADDR_W-16)'b0, latched mar}. It holds its value after the access until the next accepted request.

## Timing
- Reset values: state IDLE, mdr_in 0, hex_out 0, sram_addr 0, sram_wdata 0, mem_ready 0, busy 0, and all strobes 1.
- Reset asserted mid-access takes effect immediately (asynchronous): strobes go to 1, state to IDLE, and no mem_ready pulse is produced.
- SRAM access, request sampled at edge T:
  - ACCESS occupies cycles T+1..T+WAIT_CYCLES.
  - DONE (mem_ready=1) is in cycle T+WAIT_CYCLES+1.
  - For a read, mdr_in is valid from T+WAIT_CYCLES+1 onward.
  - Total latency is WAIT_CYCLES+1 cycles to ready.
- I/O access: IO in T+1, DONE in T+2. mdr_in/hex_out update at the end of T+1.
- Strobes are registered outputs with no glitches. sram_we_n and sram_oe_n are never low in the same cycle.
- sram_addr and sram_wdata are stable from the first ACCESS cycle through the DONE cycle.
- Back-to-back: with mem_req high again in the IDLE cycle after DONE, the next transaction starts there. The minimum spacing between ready pulses is WAIT_CYCLES+2 cycles.
- WAIT_CYCLES=1: ACCESS lasts exactly one cycle, and read data is captured at its end.

## Test plan
- Reset: assert reset mid-ACCESS during a write → sram_we_n=1 and sram_ce_n=1 in the same cycle, busy=0, and no mem_ready pulse. hex_out=0 and mdr_in=0 after release.
- SRAM write then read, WAIT_CYCLES=2:
  - Write mar=0x3000 with mdr_out=0xBEEF → sram_we_n low for exactly 2 cycles and sram_addr=0x03000.
  - Read 0x3000, with the SRAM model returning 0xBEEF → mem_ready 3 cycles after the request and mdr_in=0xBEEF.
- I/O: sw=0x00A5 and a read at 0xFFFF → mdr_in=0x00A5, mem_ready 2 cycles after the request, and no SRAM strobe activity. A write of 0x1234 to 0xFFFF → hex_out=0x1234, with mdr_in unchanged.
- Held request: keep mem_req=1 across the DONE cycle → a second transaction starts in the following IDLE cycle, and ready pulses are spaced WAIT_CYCLES+2 apart.
- Input stability: change mar and mdr_out during ACCESS → sram_addr and sram_wdata keep the values latched at the request.
- WAIT_CYCLES=1 and WAIT_CYCLES=15: the read latency-to-ready measures 2 and 16 cycles respectively, and the captured data is correct.
